multicycle_ctrl: RTL



---
 rtl/mc_pkg.sv | 24 ++
 rtl/mc_perf_cnt.sv | 24 ++
 rtl/multicycle_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle sequencer: opcodes, ALU ops, state encodings.
package mc_pkg;

    localparam int unsigned MC_OPCODE_W = 3;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_LOAD  = 3'd2;
    localparam logic [2:0] OP_STORE = 3'd3;
    localparam logic [2:0] OP_JUMP  = 3'd4;

    localparam logic [1:0] ALU_OP_ADD = 2'b00;
    localparam logic [1:0] ALU_OP_SUB = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

endpackage

// File: rtl/mc_perf_cnt.sv
// Free-running cycle counter and retired-instruction counter, both wrap at 2^CNT_W.
module mc_perf_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (instr_done) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with shared memory port handshake.
// Optional perf counters enabled by defining MC_PERF_CNT_EN.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned OPCODE_W = MC_OPCODE_W
`ifdef MC_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode_in,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic                alu_src,
    output logic [1:0]          alu_op,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                instr_done,
    output logic [2:0]          state_out
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    instr_cnt
`endif
);

    state_t              state;
    state_t              state_nxt;
    logic [OPCODE_W-1:0] op_q;
    logic [OPCODE_W-1:0] op_nxt;

    logic is_sub;
    logic is_load;
    logic is_store;
    logic is_jump;

    // Anything not recognised (including 101-111) falls through as ADD.
    assign is_sub   = (op_q == OPCODE_W'(OP_SUB));
    assign is_load  = (op_q == OPCODE_W'(OP_LOAD));
    assign is_store = (op_q == OPCODE_W'(OP_STORE));
    assign is_jump  = (op_q == OPCODE_W'(OP_JUMP));

    assign state_out = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            op_q  <= '0;
        end else begin
            state <= state_nxt;
            op_q  <= op_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        op_nxt     = op_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_OP_ADD;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;

        case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    op_nxt    = opcode_in;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (is_jump) begin
                    pc_write   = 1'b1;
                    pc_src     = 1'b1;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end else if (is_load || is_store) begin
                    alu_src   = 1'b1;
                    state_nxt = S_MEM;
                end else begin
                    alu_op    = is_sub ? ALU_OP_SUB : ALU_OP_ADD;
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = is_store;
                if (mem_ready) begin
                    instr_done = is_store;
                    state_nxt  = is_store ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_load;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef MC_PERF_CNT_EN
    mc_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr_done(instr_done),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );
`endif

endmodule
